tt_um_strobe_sample_source: RTL and testbench
=============================================

// Module: tt_um_strobe_sample_source
// PURPOSE
//  Transmit end of the team's strobed 10-bit sample interface: produces test samples and drives the
//  moving averager's inputs (strobe + 10-bit data), then waits for its one-cycle result strobe.
//  Generator modes: ramp, LFSR, square, constant. Runs as a TinyTapeout user top, wired pin-to-pin.
//  Sets the pace of the averager pipeline and flags a missing result strobe.
// PARAMETERS
//  STEP        1      ramp increment per sample (mod 1024)
//  LFSR_SEED   10'h001  LFSR reset/restart value; must be non-zero
//  CONST_VAL   10'h155  sample value in constant mode
//  TIMEOUT     64     max WAIT_ACK cycles before declaring a missing ack (>= 8)
// PORTS
//  clk      in   1  clock
//  rst_n    in   1  reset, asynchronous, active-low
//  ena      in   1  design enabled (ignored; block is always active once out of reset)
//  ui_in    in   8  [0] run, [2:1] mode (00 ramp, 01 LFSR, 10 square, 11 const), [7:3] gap cycles 0..31
//  uo_out   out  8  sample data[7:0]
//  uio_in   in   8  [1] ack = averager result strobe; all other bits ignored
//  uio_out  out  8  [0] strobe, [3:2] data[9:8], [4] busy, [5] err (sticky), [1],[7:6] = 0
//  uio_oe   out  8  constant 8'b0011_1101 (bits 0,2,3,4,5 outputs; bits 1,6,7 inputs)
// BEHAVIOUR
//  Clock is one clk; reset is asynchronous and active-low (rst_n).
//  While rst_n=0 (and on the first edge after release), all outputs are 0: strobe=0, data=0,
//  busy=0, err=0. State = IDLE, ramp=0, LFSR=LFSR_SEED, square phase=0, counters=0.
//  FSM states: IDLE, LOAD, STROBE, WAIT_ACK, GAP. All state is registered; outputs come from registers.
//   IDLE: busy=0. If run=1, go to LOAD.
//   LOAD: sample mode and gap (sampled here only). Compute the next sample; data register updates
//     on the LOAD->STROBE edge.
//   STROBE: strobe=1 for exactly one cycle, then go to WAIT_ACK.
//   WAIT_ACK: count cycles.
//     - ack=1: go to GAP (gap>0) or to LOAD (gap=0 and run=1) or to IDLE (gap=0 and run=0).
//     - count reaches TIMEOUT-1 with no ack: set err and leave exactly as on ack.
//   GAP: wait gap cycles, then go to LOAD if run=1, else IDLE.
//  busy=1 in every state except IDLE.
//  Data (uo_out, uio_out[3:2]) holds its value from the STROBE cycle until the next LOAD->STROBE edge.
//  This is mandatory: the averager captures data again in its result-strobe cycle.
//  ack is ignored outside WAIT_ACK. An ack in the same cycle as the timeout counts as ack (err not set).
//  Averager with FILTER_POWER=2: ack arrives 5 cycles after the strobe cycle.
//  Strobe-to-strobe period is 7+gap cycles.
//  Sample rules, all widths 10 bit with modular wrap:
//   - ramp: 0, STEP, 2*STEP, ... wrapping 1023 -> 0 (mod 1024).
//   - LFSR: Fibonacci x^10+x^7+1, shifted once per sample; the first emitted value is the post-shift value.
//   - square: 4 samples 0x000, then 4 samples 0x3FF, repeating.
//   - const: CONST_VAL.
//  Each generator advances only when its own mode is emitted; the others hold.
//  Mode change takes effect at the next LOAD.
//  Dropping run mid-transaction finishes the transaction (ack/timeout, then gap) before going to IDLE.
//  Re-raising run resumes the sequences, with no restart.
//  err clears only on reset.
//  Reset mid-transaction drops strobe/data/busy to 0 asynchronously; no partial strobe may remain.
// STRUCTURE
//  Shared package: FSM state encoding, mode codes (MODE_RAMP/LFSR/SQUARE/CONST), LFSR tap constant,
//  SAMPLE_W=10. The same package holds the pin-map constants shared with the averager
//  (strobe/ack/data bit positions).
//  Sub-module tt_sample_gen: holds ramp/LFSR/square registers.
//   - inputs: advance pulse, mode
//   - output: next_sample
//  Top level holds the FSM, the gap/timeout counters, the data register and the pin map.
// TESTING
//  Use a bench model of the averager (ack 5 cycles after strobe) unless stated.
//  1 Ramp: mode=00, run=1, gap=0 -> data 0,1,2,3...
//    Strobe pulses are one cycle wide, 7 cycles apart; data is stable through each ack cycle.
//  2 LFSR: mode=01, seed 0x001 -> first 12 samples match the reference polynomial model.
//    Square mode=10 -> 000,000,000,000,3FF,3FF,3FF,3FF.
//  3 Timeout: ack tied 0, TIMEOUT=64 -> err=1 on the cycle after the 64th WAIT_ACK cycle.
//    The next strobe follows after gap; err stays 1 while acks then resume.
//  4 Gap/run: gap=3 -> period 10 cycles.
//    Drop run 1 cycle after a strobe -> ack seen, 3 gap cycles, then IDLE with busy=0 and no further strobe.
//  5 Reset mid-WAIT_ACK: rst_n=0 asynchronously -> strobe/data/busy/err=0 at once.
//    After release, ramp restarts at 0.
//  6 Ack edge cases: ack during STROBE/GAP/IDLE is ignored; ack on the timeout cycle -> err stays 0.
//    uio_oe==8'h3D is constant throughout.

Source files
------------

// File: rtl/tt_um_strobe_sample_source_pkg.sv
// Shared definitions for the strobed 10-bit sample source: FSM encoding, generator modes,
// LFSR taps and the pin map shared with the moving averager.
package tt_um_strobe_sample_source_pkg;

  localparam int SAMPLE_W = 10;
  typedef logic [SAMPLE_W-1:0] sample_t;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_LOAD     = 3'd1;
  localparam logic [2:0] ST_STROBE   = 3'd2;
  localparam logic [2:0] ST_WAIT_ACK = 3'd3;
  localparam logic [2:0] ST_GAP      = 3'd4;

  typedef enum logic [1:0] {
    MODE_RAMP   = 2'b00,
    MODE_LFSR   = 2'b01,
    MODE_SQUARE = 2'b10,
    MODE_CONST  = 2'b11
  } mode_e;

  // x^10 + x^7 + 1: feedback from bits 9 and 6
  localparam sample_t LFSR_TAPS = 10'h240;

  localparam int PIN_RUN     = 0;
  localparam int PIN_MODE_LO = 1;
  localparam int PIN_GAP_LO  = 3;
  localparam int PIN_STROBE  = 0;
  localparam int PIN_ACK     = 1;
  localparam int PIN_DATA_LO = 2;
  localparam int PIN_BUSY    = 4;
  localparam int PIN_ERR     = 5;
  localparam logic [7:0] UIO_OE_MASK = 8'h3D;

  function automatic sample_t lfsr_step(input sample_t q);
    return {q[SAMPLE_W-2:0], ^(q & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/tt_um_strobe_sample_source_if.sv
// Link between the sequencing FSM (master) and the sample generator (slave).
interface tt_um_strobe_sample_source_if;
  import tt_um_strobe_sample_source_pkg::*;

  logic    advance;
  mode_e   mode;
  sample_t next_sample;

  modport master (output advance, output mode, input next_sample);
  modport slave  (input advance, input mode, output next_sample);
endinterface

// File: rtl/tt_um_strobe_sample_source_sample_gen.sv
// Ramp / LFSR / square / constant generators. Only the generator of the selected mode
// advances, so each sequence resumes where it left off when its mode returns.
module tt_sample_gen
  import tt_um_strobe_sample_source_pkg::*;
#(
  parameter sample_t STEP      = 10'd1,
  parameter sample_t LFSR_SEED = 10'h001,
  parameter sample_t CONST_VAL = 10'h155
) (
  input  logic clk,
  input  logic rst_n,
  tt_um_strobe_sample_source_if.slave gen_if
);

  sample_t    ramp_q, ramp_d;
  sample_t    lfsr_q, lfsr_d;
  logic [2:0] sq_phase_q, sq_phase_d;
  sample_t    lfsr_next_s;

  assign lfsr_next_s = lfsr_step(lfsr_q);

  // select the sample of the current mode and advance only that generator
  always_comb begin
    ramp_d     = (gen_if.advance && gen_if.mode == MODE_RAMP)   ? ramp_q + STEP : ramp_q;
    lfsr_d     = (gen_if.advance && gen_if.mode == MODE_LFSR)   ? lfsr_next_s   : lfsr_q;
    sq_phase_d = (gen_if.advance && gen_if.mode == MODE_SQUARE) ? sq_phase_q + 3'd1 : sq_phase_q;
    case (gen_if.mode)
      MODE_RAMP:   gen_if.next_sample = ramp_q;
      MODE_LFSR:   gen_if.next_sample = lfsr_next_s;
      MODE_SQUARE: gen_if.next_sample = sq_phase_q[2] ? 10'h3FF : 10'h000;
      MODE_CONST:  gen_if.next_sample = CONST_VAL;
      default:     gen_if.next_sample = CONST_VAL;
    endcase
  end

  // generator state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ramp_q     <= 10'h000;
      lfsr_q     <= LFSR_SEED;
      sq_phase_q <= 3'd0;
    end else begin
      ramp_q     <= ramp_d;
      lfsr_q     <= lfsr_d;
      sq_phase_q <= sq_phase_d;
    end
  end

endmodule

// File: rtl/tt_um_strobe_sample_source.sv
// TinyTapeout top: paces the averager with one-cycle sample strobes, waits for its result
// strobe (ack) with a timeout, and raises a sticky error when an ack goes missing.
module tt_um_strobe_sample_source
  import tt_um_strobe_sample_source_pkg::*;
#(
  parameter sample_t STEP      = 10'd1,
  parameter sample_t LFSR_SEED = 10'h001,
  parameter sample_t CONST_VAL = 10'h155,
  parameter int      TIMEOUT   = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  // counter is shared by WAIT_ACK (up to TIMEOUT-1) and GAP (up to 30)
  localparam int CNT_W = ($clog2(TIMEOUT) > 5) ? $clog2(TIMEOUT) : 5;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]       gap_q, gap_d;
  sample_t          data_q, data_d;
  logic             strobe_q, strobe_d;
  logic             busy_q, busy_d;
  logic             err_q, err_d;

  logic       run_s;
  logic       ack_s;
  mode_e      mode_s;
  logic [4:0] gap_in_s;
  logic       unused_pins_s;

  assign run_s         = ui_in[PIN_RUN];
  assign mode_s        = mode_e'(ui_in[PIN_MODE_LO +: 2]);
  assign gap_in_s      = ui_in[PIN_GAP_LO +: 5];
  assign ack_s         = uio_in[PIN_ACK];
  assign unused_pins_s = &{1'b0, ena, uio_in[7:2], uio_in[0]};

  tt_um_strobe_sample_source_if gen_if ();

  tt_sample_gen #(
    .STEP      (STEP),
    .LFSR_SEED (LFSR_SEED),
    .CONST_VAL (CONST_VAL)
  ) u_gen (
    .clk    (clk),
    .rst_n  (rst_n),
    .gen_if (gen_if.slave)
  );

  // sequencing FSM; mode and gap are only looked at in LOAD
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    gap_d          = gap_q;
    data_d         = data_q;
    err_d          = err_q;
    gen_if.advance = 1'b0;
    gen_if.mode    = mode_s;
    case (state_q)
      ST_IDLE: begin
        if (run_s) state_d = ST_LOAD;
        else       state_d = ST_IDLE;
      end
      ST_LOAD: begin
        gap_d          = gap_in_s;
        data_d         = gen_if.next_sample;
        gen_if.advance = 1'b1;
        state_d        = ST_STROBE;
      end
      ST_STROBE: begin
        cnt_d   = CNT_ZERO;
        state_d = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        // an ack on the final count wins over the timeout
        if (ack_s || cnt_q == CNT_LAST) begin
          err_d = err_q | ~ack_s;
          cnt_d = CNT_ZERO;
          if (gap_q != 5'd0) state_d = ST_GAP;
          else if (run_s)    state_d = ST_LOAD;
          else               state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_GAP: begin
        if (cnt_q == CNT_W'(gap_q - 5'd1)) begin
          cnt_d   = CNT_ZERO;
          state_d = run_s ? ST_LOAD : ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    strobe_d = (state_d == ST_STROBE);
    busy_d   = (state_d != ST_IDLE);
  end

  // state, counters and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= CNT_ZERO;
      gap_q    <= 5'd0;
      data_q   <= 10'h000;
      strobe_q <= 1'b0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      gap_q    <= gap_d;
      data_q   <= data_d;
      strobe_q <= strobe_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
    end
  end

  // pin map
  always_comb begin
    uio_out                     = 8'h00;
    uio_out[PIN_STROBE]         = strobe_q;
    uio_out[PIN_DATA_LO +: 2]   = data_q[SAMPLE_W-1 -: 2];
    uio_out[PIN_BUSY]           = busy_q;
    uio_out[PIN_ERR]            = err_q;
  end

  assign uo_out = data_q[7:0];
  assign uio_oe = UIO_OE_MASK;

endmodule

// File: tb/tb_tt_um_strobe_sample_source.sv
// Scoreboard bench: stimulus pushes the expected sample per strobe, a negedge monitor pops
// and checks data, strobe width, period, err and data hold through the averager ack.
module tb_tt_um_strobe_sample_source;
  import tt_um_strobe_sample_source_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic [7:0] ui_in = 8'h00;
  logic [7:0] uo_out, uio_in, uio_out, uio_oe;
  logic       ack_model = 1'b0;
  logic       ack_force = 1'b0;

  assign uio_in = {6'b000000, ack_model | ack_force, 1'b0};

  tt_um_strobe_sample_source dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uo_out(uo_out),
    .uio_in(uio_in), .uio_out(uio_out), .uio_oe(uio_oe)
  );

  tt_um_strobe_sample_source_if mon_if ();
  assign mon_if.advance     = uio_out[0];
  assign mon_if.mode        = mode_e'(ui_in[2:1]);
  assign mon_if.next_sample = {uio_out[3:2], uo_out};

  always #5 clk = ~clk;

  typedef struct { int data; int period; bit err; } exp_t;
  exp_t sb[$];

  int  checks = 0, failures = 0;
  int  cyc = 0;
  int  strobe_count = 0;
  int  last_strobe_cyc = -1;
  bit  ack_en = 1'b1;
  bit  exp_err = 1'b0;
  int  next_base = 0;
  int  prev_gap = 0;
  int  ramp_m = 0, lfsr_m = 1, sq_m = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // reference sample rules in plain arithmetic
  task automatic model_next(input int mode, output int v);
    case (mode)
      0: begin v = ramp_m; ramp_m = (ramp_m + 1) % 1024; end
      1: begin
        lfsr_m = ((lfsr_m * 2) % 1024) | (((lfsr_m >> 9) ^ (lfsr_m >> 6)) & 1);
        v = lfsr_m;
      end
      2: begin v = ((sq_m / 4) % 2 == 1) ? 1023 : 0; sq_m = (sq_m + 1) % 8; end
      default: v = 341;
    endcase
  endtask

  // monitor + averager model (ack 5 cycles after each strobe)
  initial begin : monitor
    bit   prev_strobe;
    bit   ack_pending;
    int   ack_cyc;
    int   held;
    int   data;
    exp_t e;
    prev_strobe = 1'b0;
    ack_pending = 1'b0;
    ack_cyc = 0;
    held = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        ack_pending = 1'b0;
        ack_model = 1'b0;
        prev_strobe = 1'b0;
        last_strobe_cyc = -1;
      end else begin
        data = int'(mon_if.next_sample);
        check("uio_oe", uio_oe, 32'h3D);
        ack_model = 1'b0;
        if (ack_pending && cyc == ack_cyc) begin
          ack_model = 1'b1;
          ack_pending = 1'b0;
          check("hold_at_ack", data, held);
        end
        if (mon_if.advance) begin
          check("strobe_width", prev_strobe, 0);
          if (sb.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_strobe actual=%0h expected=none", data);
          end else begin
            e = sb.pop_front();
            checks++;
            if (data != e.data) begin
              failures++;
              $display("FAIL sample_data actual=%0h expected=%0h mode=%0d", data, e.data, mon_if.mode);
            end
            check("err_at_strobe", uio_out[5], e.err);
            if (e.period != 0 && last_strobe_cyc >= 0)
              check("strobe_period", cyc - last_strobe_cyc, e.period);
          end
          held = data;
          last_strobe_cyc = cyc;
          strobe_count++;
          if (ack_en) begin ack_pending = 1'b1; ack_cyc = cyc + 5; end
        end
        prev_strobe = mon_if.advance;
      end
    end
  end

  // issue one transaction and wait (bounded) for its strobe; returns just after that strobe
  task automatic do_strobe(input int mode, input int gap, input bit noack);
    exp_t       e;
    int         v, start;
    bit         seen;
    logic [1:0] m;
    logic [4:0] g;
    m = mode[1:0];
    g = gap[4:0];
    ack_en = !noack;
    ui_in = {g, m, 1'b1};
    model_next(mode, v);
    e.data = v;
    e.period = (next_base == 0) ? 0 : next_base + prev_gap;
    e.err = exp_err;
    sb.push_back(e);
    next_base = noack ? 66 : 7;
    prev_gap = gap;
    start = strobe_count;
    seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk); #1;
      if (strobe_count != start) seen = 1'b1;
    end
    if (!seen) begin
      checks++; failures++;
      $display("FAIL strobe_timeout actual=none expected=strobe");
      sb.delete();
    end
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int s;
    // reset state
    wait_neg(3);
    check("rst_uo_out", uo_out, 0);
    check("rst_uio_out", uio_out, 0);
    check("rst_uio_oe", uio_oe, 32'h3D);
    @(negedge clk); rst_n = 1'b1;
    wait_neg(1);
    check("post_rel_uio_out", uio_out, 0);
    check("post_rel_uo_out", uo_out, 0);

    // ramp, LFSR, square, const (continuous run)
    for (int i = 0; i < 10; i++) do_strobe(0, 0, 1'b0);
    for (int i = 0; i < 12; i++) do_strobe(1, 0, 1'b0);
    for (int i = 0; i < 9; i++)  do_strobe(2, 0, 1'b0);
    for (int i = 0; i < 4; i++)  do_strobe(3, 2, 1'b0);

    // ack during STROBE, then during GAP, must be ignored
    do_strobe(0, 3, 1'b0);
    ack_force = 1'b1; wait_neg(1); ack_force = 1'b0;
    do_strobe(2, 3, 1'b0);
    wait_neg(6); ack_force = 1'b1; wait_neg(1); ack_force = 1'b0;
    do_strobe(1, 0, 1'b0);

    // ack exactly on the timeout cycle counts as ack
    do_strobe(0, 0, 1'b1);
    wait_neg(64);
    ack_force = 1'b1;
    wait_neg(1);
    ack_force = 1'b0;
    check("err_ack_on_timeout", uio_out[5], 0);

    // randomized modes and gaps
    for (int i = 0; i < 20; i++)
      do_strobe($urandom_range(0, 3), ($urandom_range(0, 7) == 0) ? 31 : $urandom_range(0, 4), 1'b0);

    // missing ack -> sticky err
    do_strobe(0, 0, 1'b0);
    do_strobe(0, 0, 1'b1);
    wait_neg(64);
    check("err_before_timeout", uio_out[5], 0);
    check("busy_in_wait", uio_out[4], 1);
    wait_neg(1);
    check("err_after_timeout", uio_out[5], 1);
    exp_err = 1'b1;
    for (int i = 0; i < 3; i++) do_strobe(0, 0, 1'b0);

    // drop run one cycle after a strobe with gap=3
    do_strobe(2, 3, 1'b0);
    wait_neg(1);
    ui_in[0] = 1'b0;
    wait_neg(7);
    check("busy_last_gap", uio_out[4], 1);
    wait_neg(1);
    check("busy_idle", uio_out[4], 0);
    s = strobe_count;
    ack_force = 1'b1; wait_neg(10); ack_force = 1'b0;
    wait_neg(20);
    check("no_strobe_idle", strobe_count, s);
    check("busy_stays_idle", uio_out[4], 0);
    check("err_sticky_idle", uio_out[5], 1);
    next_base = 0;

    // asynchronous reset in WAIT_ACK
    do_strobe(0, 0, 1'b0);
    do_strobe(0, 0, 1'b0);
    wait_neg(1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_uio_out", uio_out, 0);
    check("async_rst_uo_out", uo_out, 0);
    sb.delete();
    ramp_m = 0; lfsr_m = 1; sq_m = 0;
    exp_err = 1'b0; next_base = 0;
    wait_neg(3);
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 3; i++) do_strobe(0, 0, 1'b0);
    do_strobe(1, 0, 1'b0);

    ui_in[0] = 1'b0;
    wait_neg(20);
    check("scoreboard_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
